// File: rtl/rv32_pkg.sv
// ----------------------------------------------------------------------------
// rv32_pkg
// Shared types for the OF->EX issue register.
//   rv32_issue_state_e  : issue-register control state (RUN / HOLD / BUBBLE)
//   rv32_issue_packet_t : control side of the EX register (valid + latched
//                         source selects used to refresh held operands)
//   NOP_INSTR           : canonical RV32 NOP encoding (addi x0, x0, 0)
//   sat_inc16           : saturating 16-bit increment for perf counters
// ----------------------------------------------------------------------------
package rv32_pkg;

    localparam int unsigned REG_SEL_W = 5;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        BUBBLE = 2'd2
    } rv32_issue_state_e;

    typedef struct packed {
        logic                 valid;
        logic [REG_SEL_W-1:0] rs1_sel;
        logic [REG_SEL_W-1:0] rs2_sel;
    } rv32_issue_packet_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/rv32_operand_resolve.sv
// ----------------------------------------------------------------------------
// rv32_operand_resolve
// Resolves one source operand: x0 always reads zero and is never forwarded;
// otherwise a forwarded value overrides the register-file / held value.
//   i_sel      : source register index
//   i_fwd_en   : forward override enable for this operand
//   i_fwd_data : forwarded value
//   i_rf_data  : base value (register-file read, or the currently held value)
//   o_val      : resolved operand
// ----------------------------------------------------------------------------
module rv32_operand_resolve
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [REG_SEL_W-1:0] i_sel,
    input  logic                 i_fwd_en,
    input  logic [XLEN-1:0]      i_fwd_data,
    input  logic [XLEN-1:0]      i_rf_data,
    output logic [XLEN-1:0]      o_val
);

    assign o_val = (i_sel == '0) ? '0 : (i_fwd_en ? i_fwd_data : i_rf_data);

endmodule

// File: rtl/of_ex_operand_issue.sv
// ----------------------------------------------------------------------------
// of_ex_operand_issue
// OF->EX pipeline register. Captures decoded operands with forwarding
// overrides, holds under stall_ofex while still absorbing forwarded values,
// and inserts LOAD_USE_BUBBLES bubbles per load-use hazard.
//   clk, resetn                      : clock, synchronous active-low reset
//   of_valid, of_rs*_sel, of_rs*_rf  : operand-fetch instruction and RF data
//   of_payload                       : opaque decoded control for EX
//   fwd_rs*_enable, fwd_rs*_data     : forward packet (valid only this cycle)
//   stall_ofex, load_use_hazard      : hold request, load-use hazard
//   flush                            : kill EX contents (branch redirect)
//   of_ready                         : OF may advance this cycle
//   ex_valid, ex_rs*_data, ex_payload: EX-side issue packet
//   bubble_count                     : saturating count of inserted bubbles
// ----------------------------------------------------------------------------
module of_ex_operand_issue
    import rv32_pkg::*;
#(
    parameter int                   XLEN             = 32,
    parameter int                   PAYLOAD_W        = 64,
    parameter int                   LOAD_USE_BUBBLES = 1,
    parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD      = '0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 of_valid,
    input  logic [4:0]           of_rs1_sel,
    input  logic [4:0]           of_rs2_sel,
    input  logic [XLEN-1:0]      of_rs1_rf,
    input  logic [XLEN-1:0]      of_rs2_rf,
    input  logic [PAYLOAD_W-1:0] of_payload,
    input  logic                 fwd_rs1_enable,
    input  logic [XLEN-1:0]      fwd_rs1_data,
    input  logic                 fwd_rs2_enable,
    input  logic [XLEN-1:0]      fwd_rs2_data,
    input  logic                 stall_ofex,
    input  logic                 load_use_hazard,
    input  logic                 flush,
    output logic                 of_ready,
    output logic                 ex_valid,
    output logic [XLEN-1:0]      ex_rs1_data,
    output logic [XLEN-1:0]      ex_rs2_data,
    output logic [PAYLOAD_W-1:0] ex_payload,
    output logic [15:0]          bubble_count
);

    // Bubbles after the first one are counted down in BUBBLE.
    localparam logic [1:0] BUB_RELOAD   = 2'(LOAD_USE_BUBBLES - 1);
    localparam bit         MULTI_BUBBLE = (LOAD_USE_BUBBLES > 1);

    rv32_issue_state_e   r_state,   w_state_nxt;
    logic [1:0]          r_bub_cnt, w_bub_cnt_nxt;
    rv32_issue_packet_t  r_ctl,     w_ctl_nxt;
    logic [XLEN-1:0]     r_rs1,     w_rs1_nxt;
    logic [XLEN-1:0]     r_rs2,     w_rs2_nxt;
    logic [PAYLOAD_W-1:0] r_payload, w_payload_nxt;
    logic [15:0]         r_bubble_count;
    logic                w_bubble_inc;

    // In HOLD the resolvers refresh the held operands using the selects
    // latched at capture; otherwise they resolve the incoming OF operands.
    logic                w_use_held;
    logic [4:0]          w_rs1_sel, w_rs2_sel;
    logic [XLEN-1:0]     w_rs1_base, w_rs2_base;
    logic [XLEN-1:0]     w_rs1_res, w_rs2_res;

    assign w_use_held = (r_state == HOLD);
    assign w_rs1_sel  = w_use_held ? r_ctl.rs1_sel : of_rs1_sel;
    assign w_rs2_sel  = w_use_held ? r_ctl.rs2_sel : of_rs2_sel;
    assign w_rs1_base = w_use_held ? r_rs1 : of_rs1_rf;
    assign w_rs2_base = w_use_held ? r_rs2 : of_rs2_rf;

    rv32_operand_resolve #(.XLEN(XLEN)) u_rs1_resolve (
        .i_sel      (w_rs1_sel),
        .i_fwd_en   (fwd_rs1_enable),
        .i_fwd_data (fwd_rs1_data),
        .i_rf_data  (w_rs1_base),
        .o_val      (w_rs1_res)
    );

    rv32_operand_resolve #(.XLEN(XLEN)) u_rs2_resolve (
        .i_sel      (w_rs2_sel),
        .i_fwd_en   (fwd_rs2_enable),
        .i_fwd_data (fwd_rs2_data),
        .i_rf_data  (w_rs2_base),
        .o_val      (w_rs2_res)
    );

    assign of_ready = (r_state == RUN) && !load_use_hazard && !stall_ofex;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned (which would infer a latch).
        w_state_nxt   = r_state;
        w_bub_cnt_nxt = r_bub_cnt;
        w_ctl_nxt     = r_ctl;
        w_rs1_nxt     = r_rs1;
        w_rs2_nxt     = r_rs2;
        w_payload_nxt = r_payload;
        w_bubble_inc  = 1'b0;

        if (flush) begin
            w_state_nxt     = RUN;
            w_bub_cnt_nxt   = '0;
            w_ctl_nxt.valid = 1'b0;
            w_payload_nxt   = NOP_PAYLOAD;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (stall_ofex) begin
                        w_state_nxt = HOLD;
                    end else if (of_valid && load_use_hazard) begin
                        w_ctl_nxt.valid = 1'b0;
                        w_payload_nxt   = NOP_PAYLOAD;
                        w_bub_cnt_nxt   = BUB_RELOAD;
                        w_bubble_inc    = 1'b1;
                        w_state_nxt     = MULTI_BUBBLE ? BUBBLE : RUN;
                    end else begin
                        w_ctl_nxt.valid   = of_valid;
                        w_ctl_nxt.rs1_sel = of_rs1_sel;
                        w_ctl_nxt.rs2_sel = of_rs2_sel;
                        w_rs1_nxt         = w_rs1_res;
                        w_rs2_nxt         = w_rs2_res;
                        w_payload_nxt     = of_valid ? of_payload : NOP_PAYLOAD;
                    end
                end
                HOLD: begin
                    // Forwarded values keep landing on the held instruction,
                    // including the release cycle.
                    w_rs1_nxt = w_rs1_res;
                    w_rs2_nxt = w_rs2_res;
                    if (!stall_ofex) begin
                        w_state_nxt = RUN;
                    end
                end
                BUBBLE: begin
                    // A stall freezes the countdown; no bubble is counted.
                    if (!stall_ofex) begin
                        w_bubble_inc  = 1'b1;
                        w_bub_cnt_nxt = r_bub_cnt - 2'd1;
                        if (r_bub_cnt == 2'd1) begin
                            w_state_nxt = RUN;
                        end
                    end
                end
                default: begin
                    w_state_nxt = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the values from before this edge.
        if (!resetn) begin
            r_state        <= RUN;
            r_bub_cnt      <= '0;
            r_ctl          <= '0;
            r_rs1          <= '0;
            r_rs2          <= '0;
            r_payload      <= NOP_PAYLOAD;
            r_bubble_count <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bub_cnt <= w_bub_cnt_nxt;
            r_ctl     <= w_ctl_nxt;
            r_rs1     <= w_rs1_nxt;
            r_rs2     <= w_rs2_nxt;
            r_payload <= w_payload_nxt;
            if (w_bubble_inc) begin
                r_bubble_count <= sat_inc16(r_bubble_count);
            end
        end
    end

    assign ex_valid     = r_ctl.valid;
    assign ex_rs1_data  = r_rs1;
    assign ex_rs2_data  = r_rs2;
    assign ex_payload   = r_payload;
    assign bubble_count = r_bubble_count;

endmodule

// File: tb/tb_of_ex_operand_issue.sv
// ----------------------------------------------------------------------------
// tb_of_ex_operand_issue
// Directed scenarios with literal expectations followed by randomized
// traffic, all checked every cycle against a behavioural model.
// ----------------------------------------------------------------------------
module tb_of_ex_operand_issue;

    localparam int          XLEN      = 32;
    localparam int          PAYLOAD_W = 64;
    localparam int          LUB       = 2;
    localparam logic [63:0] TB_NOP    = 64'hA5A5_0000_0000_0013;

    logic        clk = 1'b0;
    logic        resetn;
    logic        of_valid;
    logic [4:0]  of_rs1_sel, of_rs2_sel;
    logic [31:0] of_rs1_rf, of_rs2_rf;
    logic [63:0] of_payload;
    logic        fwd_rs1_enable, fwd_rs2_enable;
    logic [31:0] fwd_rs1_data, fwd_rs2_data;
    logic        stall_ofex, load_use_hazard, flush;
    logic        of_ready, ex_valid;
    logic [31:0] ex_rs1_data, ex_rs2_data;
    logic [63:0] ex_payload;
    logic [15:0] bubble_count;

    int n_cmp  = 0;
    int n_fail = 0;

    of_ex_operand_issue #(
        .XLEN             (XLEN),
        .PAYLOAD_W        (PAYLOAD_W),
        .LOAD_USE_BUBBLES (LUB),
        .NOP_PAYLOAD      (TB_NOP)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .of_valid        (of_valid),
        .of_rs1_sel      (of_rs1_sel),
        .of_rs2_sel      (of_rs2_sel),
        .of_rs1_rf       (of_rs1_rf),
        .of_rs2_rf       (of_rs2_rf),
        .of_payload      (of_payload),
        .fwd_rs1_enable  (fwd_rs1_enable),
        .fwd_rs1_data    (fwd_rs1_data),
        .fwd_rs2_enable  (fwd_rs2_enable),
        .fwd_rs2_data    (fwd_rs2_data),
        .stall_ofex      (stall_ofex),
        .load_use_hazard (load_use_hazard),
        .flush           (flush),
        .of_ready        (of_ready),
        .ex_valid        (ex_valid),
        .ex_rs1_data     (ex_rs1_data),
        .ex_rs2_data     (ex_rs2_data),
        .ex_payload      (ex_payload),
        .bubble_count    (bubble_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The EX slot is either free-flowing, parked behind a stall, or still
    // owing some bubbles; the slot contents are tracked as plain values.
    bit          m_init = 1'b0;
    bit          m_valid;
    logic [31:0] m_rs1, m_rs2;
    logic [63:0] m_payload;
    logic [4:0]  m_sel1, m_sel2;
    bit          m_parked;
    int          m_bubbles_owed;
    int          m_bubbles;

    function automatic logic [31:0] operand(input logic [4:0] sel, input logic en,
                                            input logic [31:0] fwd, input logic [31:0] base);
        if (sel == 5'd0) return 32'd0;
        return en ? fwd : base;
    endfunction

    task automatic model_step();
        if (!resetn) begin
            m_init = 1'b1; m_valid = 1'b0; m_rs1 = '0; m_rs2 = '0; m_payload = TB_NOP;
            m_sel1 = '0; m_sel2 = '0; m_parked = 1'b0; m_bubbles_owed = 0; m_bubbles = 0;
        end else if (flush) begin
            m_valid = 1'b0; m_payload = TB_NOP; m_parked = 1'b0; m_bubbles_owed = 0;
        end else if (m_bubbles_owed > 0) begin
            if (!stall_ofex) begin
                m_bubbles_owed--;
                if (m_bubbles < 65535) m_bubbles++;
            end
        end else if (m_parked) begin
            m_rs1 = operand(m_sel1, fwd_rs1_enable, fwd_rs1_data, m_rs1);
            m_rs2 = operand(m_sel2, fwd_rs2_enable, fwd_rs2_data, m_rs2);
            if (!stall_ofex) m_parked = 1'b0;
        end else if (stall_ofex) begin
            m_parked = 1'b1;
        end else if (of_valid && load_use_hazard) begin
            m_valid = 1'b0; m_payload = TB_NOP;
            if (m_bubbles < 65535) m_bubbles++;
            m_bubbles_owed = LUB - 1;
        end else begin
            m_valid   = of_valid;
            m_sel1    = of_rs1_sel;
            m_sel2    = of_rs2_sel;
            m_rs1     = operand(of_rs1_sel, fwd_rs1_enable, fwd_rs1_data, of_rs1_rf);
            m_rs2     = operand(of_rs2_sel, fwd_rs2_enable, fwd_rs2_data, of_rs2_rf);
            m_payload = of_valid ? of_payload : TB_NOP;
        end
    endtask

    // Single compare process: registered outputs after each edge, and
    // of_ready from the model's slot status plus the inputs still applied.
    always @(negedge clk) begin
        if (m_init) begin
            check("ex_valid", 64'(ex_valid), 64'(m_valid));
            check("ex_payload", ex_payload, m_payload);
            check("bubble_count", 64'(bubble_count), 64'(m_bubbles));
            check("of_ready", 64'(of_ready),
                  64'(!m_parked && m_bubbles_owed == 0 && !load_use_hazard && !stall_ofex));
            if (m_valid) begin
                check("ex_rs1_data", 64'(ex_rs1_data), 64'(m_rs1));
                check("ex_rs2_data", 64'(ex_rs2_data), 64'(m_rs2));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_idle();
        resetn = 1'b1; of_valid = 1'b0; of_rs1_sel = '0; of_rs2_sel = '0;
        of_rs1_rf = '0; of_rs2_rf = '0; of_payload = '0;
        fwd_rs1_enable = 1'b0; fwd_rs1_data = '0; fwd_rs2_enable = 1'b0; fwd_rs2_data = '0;
        stall_ofex = 1'b0; load_use_hazard = 1'b0; flush = 1'b0;
    endtask

    task automatic set_instr(input logic [4:0] s1, input logic [31:0] d1,
                             input logic [4:0] s2, input logic [31:0] d2, input logic [63:0] p);
        of_valid = 1'b1; of_rs1_sel = s1; of_rs1_rf = d1;
        of_rs2_sel = s2; of_rs2_rf = d2; of_payload = p;
    endtask

    // Inputs are applied before the call; returns 1 time unit after the
    // following falling edge, after the model has taken the rising edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_ready(input string name, input logic exp);
        #1;
        check(name, 64'(of_ready), 64'(exp));
    endtask

    task automatic expect_reset_values(input string tag);
        check({tag, "_valid"}, 64'(ex_valid), 64'd0);
        check({tag, "_payload"}, ex_payload, TB_NOP);
        check({tag, "_bubbles"}, 64'(bubble_count), 64'd0);
        check({tag, "_rs1"}, 64'(ex_rs1_data), 64'd0);
        check({tag, "_rs2"}, 64'(ex_rs2_data), 64'd0);
        check({tag, "_ready"}, 64'(of_ready), 64'd1);
    endtask

    initial begin
        set_idle();
        resetn = 1'b0;
        tick(); tick();
        expect_reset_values("cold_reset");
        resetn = 1'b1;

        // Plain issue.
        set_instr(5'd5, 32'h11, 5'd6, 32'h22, 64'h1111);
        tick();
        check("plain_valid", 64'(ex_valid), 64'd1);
        check("plain_rs1", 64'(ex_rs1_data), 64'h11);
        check("plain_rs2", 64'(ex_rs2_data), 64'h22);
        check("plain_payload", ex_payload, 64'h1111);

        // Forwarding, with x0 immune to forwarding.
        set_instr(5'd0, 32'h77, 5'd7, 32'h99, 64'h2222);
        fwd_rs1_enable = 1'b1; fwd_rs1_data = 32'hDEAD;
        fwd_rs2_enable = 1'b1; fwd_rs2_data = 32'hBEEF;
        tick();
        check("fwd_x0_rs1", 64'(ex_rs1_data), 64'd0);
        check("fwd_rs2", 64'(ex_rs2_data), 64'hBEEF);

        // Hold for three cycles; a forward in the second refreshes rs2.
        set_instr(5'd1, 32'h33, 5'd2, 32'h44, 64'h3333);
        fwd_rs1_enable = 1'b0; fwd_rs2_enable = 1'b0;
        stall_ofex = 1'b1;
        expect_ready("hold_ready_c1", 1'b0);
        tick();
        fwd_rs1_enable = 1'b1; fwd_rs1_data = 32'h5555;
        fwd_rs2_enable = 1'b1; fwd_rs2_data = 32'h1234;
        expect_ready("hold_ready_c2", 1'b0);
        tick();
        fwd_rs1_enable = 1'b0; fwd_rs2_enable = 1'b0;
        expect_ready("hold_ready_c3", 1'b0);
        tick();
        check("hold_rs2_refresh", 64'(ex_rs2_data), 64'h1234);
        check("hold_rs1_x0", 64'(ex_rs1_data), 64'd0);
        check("hold_payload", ex_payload, 64'h2222);
        check("hold_valid", 64'(ex_valid), 64'd1);
        stall_ofex = 1'b0;
        expect_ready("hold_release_ready", 1'b0);
        tick();
        check("hold_release_payload", ex_payload, 64'h2222);
        expect_ready("after_hold_ready", 1'b1);
        tick();
        check("after_hold_capture", ex_payload, 64'h3333);

        // Load-use hazard pulse: two bubbles, then the instruction issues.
        set_instr(5'd3, 32'h55, 5'd4, 32'h66, 64'h4444);
        load_use_hazard = 1'b1;
        expect_ready("lu_ready_c1", 1'b0);
        tick();
        check("lu_valid_c1", 64'(ex_valid), 64'd0);
        check("lu_payload_c1", ex_payload, TB_NOP);
        check("lu_count_c1", 64'(bubble_count), 64'd1);
        load_use_hazard = 1'b0;
        expect_ready("lu_ready_c2", 1'b0);
        tick();
        check("lu_valid_c2", 64'(ex_valid), 64'd0);
        check("lu_count_c2", 64'(bubble_count), 64'd2);
        expect_ready("lu_ready_c3", 1'b1);
        tick();
        check("lu_issue_valid", 64'(ex_valid), 64'd1);
        check("lu_issue_payload", ex_payload, 64'h4444);

        // Flush while holding drops the held instruction.
        stall_ofex = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        check("flush_valid", 64'(ex_valid), 64'd0);
        check("flush_payload", ex_payload, TB_NOP);
        set_idle();
        expect_ready("flush_state_run", 1'b1);
        tick();

        // Reset in the middle of a bubble run.
        set_instr(5'd8, 32'h88, 5'd9, 32'h99, 64'h5555);
        load_use_hazard = 1'b1;
        tick();
        set_idle();
        resetn = 1'b0;
        tick();
        expect_reset_values("bubble_reset");
        resetn = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            resetn          = ($urandom_range(63) != 0);
            of_valid        = ($urandom_range(9) < 8);
            of_rs1_sel      = ($urandom_range(4) == 0) ? 5'd0 : 5'($urandom_range(31));
            of_rs2_sel      = ($urandom_range(4) == 0) ? 5'd0 : 5'($urandom_range(31));
            of_rs1_rf       = $urandom;
            of_rs2_rf       = $urandom;
            of_payload      = {$urandom, $urandom};
            fwd_rs1_enable  = ($urandom_range(9) < 3);
            fwd_rs1_data    = $urandom;
            fwd_rs2_enable  = ($urandom_range(9) < 3);
            fwd_rs2_data    = $urandom;
            stall_ofex      = ($urandom_range(9) < 2);
            load_use_hazard = ($urandom_range(19) < 3);
            flush           = ($urandom_range(19) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
